// File: rtl/axi_llc_arcane_lock_mgr.sv
// LLC exclusive-access lock manager: round-robin arbitration of lock requests,
// LLC isolation handshake with timeout, and sticky error reporting.
module axi_llc_arcane_lock_mgr #(
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumReq-1:0]                      acq_req_i,
    input  logic [NumReq-1:0]                      rel_req_i,
    input  logic                                   flush_busy_i,
    input  logic                                   llc_isolated_i,
    input  logic                                   ar_unit_busy_i,
    input  logic                                   aw_unit_busy_i,
    input  logic                                   err_clr_i,
    output logic                                   llc_isolate_o,
    output logic [NumReq-1:0]                      grant_o,
    output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0] owner_o,
    output logic                                   locked_o,
    output logic                                   err_o,
    output logic [1:0]                             err_code_o
);

    localparam int OwnW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam bit TimeoutEn = (TimeoutCycles > 0);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
    localparam logic [NumReq-1:0] One = 1;
    localparam logic [OwnW-1:0] LastIdx = OwnW'(NumReq - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        LOCK    = 2'd2,
        ERR     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [OwnW-1:0]   owner_q, owner_d;
    logic [OwnW-1:0]   rr_q, rr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        code_q, code_d;

    logic [OwnW-1:0]   win;
    logic              found;
    int                idx;
    logic [NumReq-1:0] sh;
    logic [NumReq-1:0] own_oh;
    logic              own_acq;
    logic              ready;
    logic [OwnW-1:0]   rr_nxt;

    assign own_oh  = One << owner_q;
    assign own_acq = |(acq_req_i & own_oh);
    assign ready   = llc_isolated_i & ~ar_unit_busy_i & ~aw_unit_busy_i;
    assign rr_nxt  = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

    // Rotating search starting at rr_q, which holds (last owner + 1).
    always_comb begin
        win   = rr_q;
        found = 1'b0;
        idx   = 0;
        sh    = '0;
        for (int i = 0; i < NumReq; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            sh = acq_req_i >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                win   = OwnW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (!flush_busy_i && found) begin
                    owner_d = win;
                    cnt_d   = '0;
                    state_d = ISOLATE;
                end
            end
            ISOLATE: begin
                if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
                if (!own_acq) begin
                    state_d = IDLE;
                end else if (ready) begin
                    state_d = LOCK;
                    rr_d    = rr_nxt;
                end else if (TimeoutEn && cnt_q == CntMax) begin
                    state_d = ERR;
                    code_d  = 2'd1;
                end
            end
            LOCK: begin
                if (!llc_isolated_i) begin
                    state_d = ERR;
                    code_d  = 2'd2;
                end else if (|(rel_req_i & own_oh)) begin
                    state_d = IDLE;
                end else if (|(rel_req_i & ~own_oh)) begin
                    state_d = ERR;
                    code_d  = 2'd3;
                end
            end
            ERR: begin
                if (err_clr_i) begin
                    state_d = IDLE;
                    code_d  = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign llc_isolate_o = (state_q != IDLE);
    assign locked_o      = (state_q == LOCK);
    assign grant_o       = (state_q == LOCK) ? own_oh : '0;
    assign err_o         = (state_q == ERR);
    assign err_code_o    = code_q;
    assign owner_o       = owner_q;

endmodule

// File: tb/tb_axi_llc_arcane_lock_mgr.sv
// Bench for axi_llc_arcane_lock_mgr: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_axi_llc_arcane_lock_mgr;

    localparam int N  = 2;
    localparam int TO = 8;

    logic       clk, rst_n;
    logic [1:0] acq, rel;
    logic       flush, iso, arb, awb, clr;
    logic       llc_iso, locked, err;
    logic [1:0] grant, code;
    logic [0:0] owner;

    int tests, fails;

    // reference model: 0 idle, 1 isolating, 2 locked, 3 error
    int m_state, m_owner, m_next, m_cnt, m_code;

    axi_llc_arcane_lock_mgr #(.NumReq(N), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .acq_req_i(acq), .rel_req_i(rel),
        .flush_busy_i(flush), .llc_isolated_i(iso),
        .ar_unit_busy_i(arb), .aw_unit_busy_i(awb),
        .err_clr_i(clr),
        .llc_isolate_o(llc_iso), .grant_o(grant), .owner_o(owner),
        .locked_o(locked), .err_o(err), .err_code_o(code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit bit_of(input logic [1:0] v, input int i);
        logic [1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    task automatic model_reset();
        m_state = 0; m_owner = 0; m_next = 0; m_cnt = 0; m_code = 0;
    endtask

    task automatic model_step(input logic [1:0] a, input logic [1:0] r,
                              input bit fl, input bit is, input bit ab,
                              input bit wb, input bit cl);
        int c;
        case (m_state)
            0: if (!fl && a != 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    c = (m_next + k) % N;
                    if (bit_of(a, c)) m_owner = c;
                end
                m_cnt = 0;
                m_state = 1;
            end
            1: begin
                if (!bit_of(a, m_owner)) m_state = 0;
                else if (is && !ab && !wb) begin
                    m_state = 2;
                    m_next = (m_owner + 1) % N;
                end else if (m_cnt == TO) begin
                    m_state = 3;
                    m_code = 1;
                end
                if (m_cnt < TO) m_cnt++;
            end
            2: begin
                if (!is) begin m_state = 3; m_code = 2; end
                else if (bit_of(r, m_owner)) m_state = 0;
                else if (r != 0) begin m_state = 3; m_code = 3; end
            end
            default: if (cl) begin m_state = 0; m_code = 0; end
        endcase
    endtask

    task automatic step();
        logic [1:0] a, r;
        bit fl, is, ab, wb, cl;
        a = acq; r = rel; fl = flush; is = iso; ab = arb; wb = awb; cl = clr;
        @(posedge clk);
        #1;
        model_step(a, r, fl, is, ab, wb, cl);
    endtask

    task automatic idle_inputs();
        acq = 0; rel = 0; flush = 0; iso = 1; arb = 0; awb = 0; clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #7;
        tests++;
        if ({llc_iso, grant, owner, locked, err, code} !== 8'b0) begin
            fails++;
            $display("FAIL reset_during: got %b want 00000000",
                     {llc_iso, grant, owner, locked, err, code});
        end
        rst_n = 1'b1;
        model_reset();
        step();
        tests++;
        if ({llc_iso, grant, owner, locked, err, code} !== 8'b0) begin
            fails++;
            $display("FAIL reset_after: got %b want 00000000",
                     {llc_iso, grant, owner, locked, err, code});
        end
    endtask

    task automatic test_basic();
        do_reset();
        acq = 2'b01;
        step();
        tests++;
        if (grant !== 2'b00 || llc_iso !== 1'b1) begin
            fails++;
            $display("FAIL basic_t1: grant %b iso %b want 00 1", grant, llc_iso);
        end
        step();
        tests++;
        if (grant !== 2'b01 || owner !== 1'b0 || locked !== 1'b1) begin
            fails++;
            $display("FAIL basic_t2: grant %b owner %b locked %b want 01 0 1",
                     grant, owner, locked);
        end
        acq = 2'b00; rel = 2'b01;
        step();
        rel = 2'b00;
        tests++;
        if (grant !== 2'b00 || llc_iso !== 1'b0) begin
            fails++;
            $display("FAIL basic_rel: grant %b iso %b want 00 0", grant, llc_iso);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp [3];
        exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01;
        do_reset();
        acq = 2'b11;
        for (int r = 0; r < 3; r++) begin
            step();
            step();
            tests++;
            if (grant !== exp[r]) begin
                fails++;
                $display("FAIL rr_round%0d: grant %b want %b", r, grant, exp[r]);
            end
            rel = grant;
            step();
            rel = 2'b00;
        end
        acq = 2'b00;
    endtask

    task automatic test_timeout();
        do_reset();
        iso = 1'b0; acq = 2'b01;
        for (int i = 0; i < 9; i++) step();
        tests++;
        if (err !== 1'b0 || llc_iso !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: err %b iso %b want 0 1", err, llc_iso);
        end
        step();
        tests++;
        if (err !== 1'b1 || code !== 2'd1 || grant !== 2'b00) begin
            fails++;
            $display("FAIL timeout_err: err %b code %0d grant %b want 1 1 00",
                     err, code, grant);
        end
        acq = 2'b00; clr = 1'b1;
        step();
        clr = 1'b0;
        tests++;
        if (err !== 1'b0 || code !== 2'd0 || llc_iso !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clr: err %b code %0d iso %b want 0 0 0",
                     err, code, llc_iso);
        end
        iso = 1'b1;
    endtask

    task automatic test_flush();
        do_reset();
        flush = 1'b1; acq = 2'b10;
        repeat (3) step();
        tests++;
        if (llc_iso !== 1'b0) begin
            fails++;
            $display("FAIL flush_hold: iso %b want 0", llc_iso);
        end
        flush = 1'b0;
        step();
        tests++;
        if (llc_iso !== 1'b1 || owner !== 1'b1) begin
            fails++;
            $display("FAIL flush_go: iso %b owner %b want 1 1", llc_iso, owner);
        end
        acq = 2'b00;
        step();
    endtask

    task automatic test_errors();
        do_reset();
        acq = 2'b01;
        step(); step();
        acq = 2'b00; rel = 2'b10;
        step();
        rel = 2'b00;
        tests++;
        if (err !== 1'b1 || code !== 2'd3) begin
            fails++;
            $display("FAIL illegal_rel: err %b code %0d want 1 3", err, code);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        acq = 2'b01;
        step(); step();
        acq = 2'b00; iso = 1'b0; rel = 2'b01;
        step();
        rel = 2'b00;
        tests++;
        if (code !== 2'd2 || llc_iso !== 1'b1 || grant !== 2'b00) begin
            fails++;
            $display("FAIL iso_lost: code %0d iso %b grant %b want 2 1 00",
                     code, llc_iso, grant);
        end
        iso = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        acq = 2'b01;
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (grant !== 2'b00 || llc_iso !== 1'b0 || locked !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: grant %b iso %b locked %b want 00 0 0",
                     grant, llc_iso, locked);
        end
        idle_inputs();
        #15;
        rst_n = 1'b1;
        model_reset();
        step();
        acq = 2'b10;
        step(); step();
        tests++;
        if (grant !== 2'b10 || owner !== 1'b1) begin
            fails++;
            $display("FAIL post_rst_grant: grant %b owner %b want 10 1",
                     grant, owner);
        end
        acq = 2'b00; rel = 2'b10;
        step();
        rel = 2'b00;
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        logic [1:0] eg;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            acq   = 2'($urandom);
            rel   = ($urandom % 6 == 0) ? 2'($urandom) : 2'b00;
            iso   = ($urandom % 10 != 0);
            arb   = ($urandom % 4 == 0);
            awb   = ($urandom % 4 == 0);
            flush = ($urandom % 5 == 0);
            clr   = ($urandom % 4 == 0);
            step();
            eg  = (m_state == 2) ? 2'(1 << m_owner) : 2'b00;
            exp = {m_state != 0, eg, 1'(m_owner), m_state == 2,
                   m_state == 3, 2'(m_code)};
            got = {llc_iso, grant, owner, locked, err, code};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL random_cyc%0d: got %b want %b", i, got, exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_flush();
        test_errors();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
